irq_arbiter: RTL and testbench

Machine-mode interrupt arbiter between the raw interrupt sources and the commit/trap sequencer. It synchronises and latches the software, timer, external and debug requests, masks them with the per-source enables and the global interrupt enable, and selects one winner by fixed priority. It presents the winner as a stable one-hot `irq_o` until the trap sequencer acknowledges it, then blocks further requests until the handler re-enables interrupts.

---
 rtl/irq_arbiter_pkg.sv | 26 ++
 rtl/irq_sync_edge.sv | 51 +++++
 rtl/irq_arbiter.sv | 137 +++++++++++++
 tb/tb_irq_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : irq_arbiter_pkg                                        |
// | Description : Shared constants and FSM encoding for irq_arbiter.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package irq_arbiter_pkg;

  // Interrupt bus width used across the core; irq_arbiter's NUM_SRC matches it.
  localparam int Interrupt_Bus = 4;

  // Source bit positions on the interrupt bus.
  localparam int IRQ_SOFT  = 0;
  localparam int IRQ_TIMER = 1;
  localparam int IRQ_EXT   = 2;
  localparam int IRQ_DBG   = 3;

  // Arbiter FSM, one-hot so that any other encoding is detectably illegal.
  typedef enum logic [2:0] {
    IRQ_S_IDLE    = 3'b001,
    IRQ_S_PRESENT = 3'b010,
    IRQ_S_SERVICE = 3'b100
  } irq_state_e;

endpackage : irq_arbiter_pkg
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : irq_sync_edge                                          |
// | Description : Per-bit optional 2-flop synchroniser followed by a     |
// |               rising-edge detector. Synchroniser present only when   |
// |               IRQ_SYNC_EN is defined.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  output logic s_o,
  output logic rise_o
);

  logic r_prev;

`ifdef IRQ_SYNC_EN
  logic r_meta;
  logic r_sync;

  // Two-flop synchroniser for a possibly asynchronous request line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= src_i;
      r_sync <= r_meta;
    end
  end

  assign s_o = r_sync;
`else
  assign s_o = src_i;
`endif

  // Edge history: previous conditioned level, for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= s_o;
    end
  end

  assign rise_o = s_o & ~r_prev;

endmodule : irq_sync_edge
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : irq_arbiter                                            |
// | Description : Machine-mode interrupt arbiter. Conditions and latches |
// |               requests, masks with enables, grants one winner by     |
// |               fixed priority (highest index) and holds it until ack. |
// |               Optional input synchronisers: define IRQ_SYNC_EN.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int                 NUM_SRC   = Interrupt_Bus,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = 4'b0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] mie_i,
  input  logic               global_int_en_i,
  input  logic               int_assert_i,
  input  logic               clr_we_i,
  input  logic [NUM_SRC-1:0] clr_mask_i,
  output logic [NUM_SRC-1:0] irq_o,
  output logic [1:0]         irq_id_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               busy_o
);

  irq_state_e         r_state;
  irq_state_e         w_state_nxt;
  logic [NUM_SRC-1:0] r_irq;
  logic [NUM_SRC-1:0] w_irq_nxt;
  logic [1:0]         r_irq_id;
  logic [1:0]         w_id_nxt;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] w_pend_nxt;
  logic [NUM_SRC-1:0] w_s;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_win_oh;
  logic [1:0]         w_win_id;
  logic [NUM_SRC-1:0] w_clr;
  logic               w_ack;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync_edge u_sync_edge (
      .clk    (clk),
      .rst    (rst),
      .src_i  (src_i[g]),
      .s_o    (w_s[g]),
      .rise_o (w_rise[g])
    );
  end

  assign w_elig = r_pending & mie_i;

  // Fixed priority: scan upwards so the highest eligible index ends up winning.
  always_comb begin
    w_win_oh = '0;
    w_win_id = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_elig[i]) begin
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
        w_win_id    = 2'(i);
      end
    end
  end

  // Next-state and grant selection; irq_o is registered and frozen in PRESENT.
  always_comb begin
    w_state_nxt = r_state;
    w_irq_nxt   = r_irq;
    w_id_nxt    = r_irq_id;
    w_ack       = 1'b0;
    case (r_state)
      IRQ_S_IDLE: begin
        w_irq_nxt = '0;
        w_id_nxt  = '0;
        if (global_int_en_i && (|w_elig)) begin
          w_state_nxt = IRQ_S_PRESENT;
          w_irq_nxt   = w_win_oh;
          w_id_nxt    = w_win_id;
        end
      end
      IRQ_S_PRESENT: begin
        if (int_assert_i) begin
          w_ack       = 1'b1;
          w_state_nxt = IRQ_S_SERVICE;
          w_irq_nxt   = '0;
          w_id_nxt    = '0;
        end
      end
      IRQ_S_SERVICE: begin
        w_irq_nxt = '0;
        w_id_nxt  = '0;
        if (global_int_en_i) begin
          w_state_nxt = IRQ_S_IDLE;
        end
      end
      default: begin
        w_state_nxt = IRQ_S_IDLE;
        w_irq_nxt   = '0;
        w_id_nxt    = '0;
      end
    endcase
  end

  // Edge bits: a new rising edge beats any clear in the same cycle. Level bits follow s.
  always_comb begin
    w_clr      = (clr_we_i ? clr_mask_i : '0) | (w_ack ? (r_irq & EDGE_MASK) : '0);
    w_pend_nxt = (EDGE_MASK & (w_rise | (r_pending & ~w_clr))) | (~EDGE_MASK & w_s);
  end

  // State, grant and pending registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IRQ_S_IDLE;
      r_irq     <= '0;
      r_irq_id  <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_irq     <= w_irq_nxt;
      r_irq_id  <= w_id_nxt;
      r_pending <= w_pend_nxt;
    end
  end

  assign irq_o     = r_irq;
  assign irq_id_o  = r_irq_id;
  assign pending_o = r_pending;
  assign busy_o    = (r_state == IRQ_S_PRESENT) || (r_state == IRQ_S_SERVICE);

endmodule : irq_arbiter
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_irq_arbiter                                         |
// | Description : Self-checking bench for irq_arbiter: vector table,     |
// |               directed corner sequences, random vs reference model.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_irq_arbiter;

`ifdef IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int PEND_LAT = SYNC_LAT + 1;   // edges until pending is visible
  localparam int IRQ_LAT  = SYNC_LAT + 2;   // edges until irq_o is visible
  localparam logic [3:0] EDGE = 4'b0100;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src, mie, clr_mask;
  logic       gie, ack, clr_we;
  logic [3:0] irq_o, pending_o;
  logic [1:0] irq_id_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  irq_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .src_i           (src),
    .mie_i           (mie),
    .global_int_en_i (gie),
    .int_assert_i    (ack),
    .clr_we_i        (clr_we),
    .clr_mask_i      (clr_mask),
    .irq_o           (irq_o),
    .irq_id_o        (irq_id_o),
    .pending_o       (pending_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; src = '0; mie = '0; gie = 1'b0; ack = 1'b0; clr_we = 1'b0; clr_mask = '0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model (behavioural) ----------------
  int         m_phase;   // 0 idle, 1 presenting, 2 in service
  int         m_win;     // granted source index, -1 when none
  logic [3:0] m_pend;
  logic [3:0] m_sprev;
  logic [3:0] m_sq[$];   // past samples of src, models the synchroniser delay

  task automatic model_reset();
    m_phase = 0; m_win = -1; m_pend = '0; m_sprev = '0;
    m_sq.delete();
    for (int k = 0; k < SYNC_LAT; k++) m_sq.push_back(4'b0000);
  endtask

  task automatic model_step();
    logic [3:0] s, rise, nxt;
    int hi;
    s    = (SYNC_LAT == 0) ? src : m_sq[m_sq.size() - SYNC_LAT];
    rise = s & ~m_sprev;
    hi   = -1;
    for (int i = 0; i < 4; i++) if (m_pend[i] && mie[i]) hi = i;
    nxt = m_pend;
    for (int i = 0; i < 4; i++) begin
      if (EDGE[i]) begin
        if (clr_we && clr_mask[i]) nxt[i] = 1'b0;
        if (m_phase == 1 && ack && m_win == i) nxt[i] = 1'b0;
        if (rise[i]) nxt[i] = 1'b1;
      end else begin
        nxt[i] = s[i];
      end
    end
    if (m_phase == 0) begin
      if (gie && hi >= 0) begin m_phase = 1; m_win = hi; end
    end else if (m_phase == 1) begin
      if (ack) begin m_phase = 2; m_win = -1; end
    end else begin
      if (gie) m_phase = 0;
    end
    m_pend  = nxt;
    m_sprev = s;
    if (SYNC_LAT > 0) begin
      m_sq.push_back(src);
      void'(m_sq.pop_front());
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] src;
    logic [3:0] mie;
    logic [3:0] exp_irq;
    logic [1:0] exp_id;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic [3:0] exp_irq;
    logic [1:0] exp_id;

    tbl[0] = '{4'b0001, 4'b1111, 4'b0001, 2'd0};
    tbl[1] = '{4'b0011, 4'b1111, 4'b0010, 2'd1};
    tbl[2] = '{4'b0111, 4'b1111, 4'b0100, 2'd2};
    tbl[3] = '{4'b1011, 4'b1111, 4'b1000, 2'd3};
    tbl[4] = '{4'b1011, 4'b0011, 4'b0010, 2'd1};
    tbl[5] = '{4'b0101, 4'b0001, 4'b0001, 2'd0};
    tbl[6] = '{4'b1111, 4'b0000, 4'b0000, 2'd0};
    tbl[7] = '{4'b0110, 4'b1110, 4'b0100, 2'd2};

    // Reset state
    rst = 1'b1; src = '0; mie = '0; gie = 1'b0; ack = 1'b0; clr_we = 1'b0; clr_mask = '0;
    tick(); tick();
    chk("rst_irq", 16'(irq_o), 16'h0);
    chk("rst_id", 16'(irq_id_o), 16'h0);
    chk("rst_pending", 16'(pending_o), 16'h0);
    chk("rst_busy", 16'(busy_o), 16'h0);
    rst = 1'b0;

    // Table: held sources, grant priority and pending latch
    for (int v = 0; v < 8; v++) begin
      do_reset();
      src = tbl[v].src; mie = tbl[v].mie; gie = 1'b1;
      for (int t = 0; t < IRQ_LAT; t++) tick();
      chk($sformatf("tbl%0d_irq", v), 16'(irq_o), 16'(tbl[v].exp_irq));
      chk($sformatf("tbl%0d_id", v), 16'(irq_id_o), 16'(tbl[v].exp_id));
      chk($sformatf("tbl%0d_pend", v), 16'(pending_o), 16'(tbl[v].src));
    end

    // External edge pulse: exact grant latency, then ack clears grant and pending
    do_reset();
    mie = 4'b0100; gie = 1'b1;
    src = 4'b0100;
    for (int t = 1; t <= IRQ_LAT; t++) begin
      tick();
      if (t == 1) src = 4'b0000;
      if (t == IRQ_LAT - 1) chk("ext_early_irq", 16'(irq_o), 16'h0);
    end
    chk("ext_irq", 16'(irq_o), 16'h4);
    chk("ext_id", 16'(irq_id_o), 16'h2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ext_ack_irq", 16'(irq_o), 16'h0);
    chk("ext_ack_pend", 16'(pending_o), 16'h0);
    chk("ext_ack_busy", 16'(busy_o), 16'h1);

    // Simultaneous 1011: debug first, then timer after re-enable; software waits
    do_reset();
    mie = 4'b1111; gie = 1'b1; src = 4'b1011;
    for (int t = 0; t < IRQ_LAT; t++) tick();
    chk("multi_first", 16'(irq_o), 16'h8);
    ack = 1'b1; gie = 1'b0; src = 4'b0011;
    tick();
    ack = 1'b0;
    chk("multi_ack_irq", 16'(irq_o), 16'h0);
    for (int t = 0; t < SYNC_LAT + 2; t++) tick();
    chk("multi_pend", 16'(pending_o), 16'h3);
    gie = 1'b1;
    tick();
    chk("multi_idle_irq", 16'(irq_o), 16'h0);
    chk("multi_idle_busy", 16'(busy_o), 16'h0);
    tick();
    chk("multi_second", 16'(irq_o), 16'h2);
    chk("multi_second_id", 16'(irq_id_o), 16'h1);
    chk("multi_soft_pend", 16'(pending_o[0]), 16'h1);

    // Level timer with gie low, then grant one cycle after gie rises
    do_reset();
    mie = 4'b0010; src = 4'b0010;
    for (int t = 0; t < PEND_LAT + 2; t++) tick();
    chk("lvl_pend", 16'(pending_o), 16'h2);
    chk("lvl_irq_gated", 16'(irq_o), 16'h0);
    gie = 1'b1;
    tick();
    chk("lvl_grant", 16'(irq_o), 16'h2);

    // No preemption by debug while presenting timer
    src = 4'b1010; mie = 4'b1111;
    for (int t = 0; t < IRQ_LAT + 2; t++) begin
      tick();
      chk("nopreempt_irq", 16'(irq_o), 16'h2);
    end
    ack = 1'b1; gie = 1'b0;
    tick();
    ack = 1'b0;
    chk("svc_irq", 16'(irq_o), 16'h0);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("mret_irq", 16'(irq_o), 16'h0);
    chk("mret_busy", 16'(busy_o), 16'h1);
    chk("mret_pend", 16'(pending_o), 16'hA);

    // Set and clear strobe in the same cycle: set wins
    do_reset();
    src = 4'b0100; clr_we = 1'b1; clr_mask = 4'b0100;
    for (int t = 0; t < PEND_LAT; t++) tick();
    clr_we = 1'b0;
    chk("setclr_pend", 16'(pending_o), 16'h4);
    tick();
    chk("setclr_hold", 16'(pending_o), 16'h4);
    mie = 4'b0100; gie = 1'b1;
    tick();
    chk("setclr_grant", 16'(irq_o), 16'h4);
    // Asynchronous reset mid-PRESENT
    #2 rst = 1'b1;
    #1;
    chk("arst_irq", 16'(irq_o), 16'h0);
    chk("arst_pend", 16'(pending_o), 16'h0);
    chk("arst_busy", 16'(busy_o), 16'h0);
    gie = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("arst_idle_busy", 16'(busy_o), 16'h0);
    chk("arst_idle_irq", 16'(irq_o), 16'h0);

    // Randomised run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) src[b] = ~src[b];
      if ($urandom_range(15) == 0) mie = 4'($urandom);
      gie      = ($urandom_range(3) != 0);
      ack      = ($urandom_range(4) == 0);
      clr_we   = ($urandom_range(9) == 0);
      clr_mask = 4'($urandom);
      @(posedge clk);
      model_step();
      #1;
      chk("rand", {irq_o, 2'(irq_id_o), pending_o, 1'(busy_o)},
          {(m_win >= 0) ? 4'(1 << m_win) : 4'b0000,
           (m_win >= 0) ? 2'(m_win) : 2'b00,
           m_pend, 1'(m_phase != 0)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_irq_arbiter
`default_nettype wire
